seq_addsub: RTL and testbench

Multi-cycle, parametrised add/subtract unit for the 8-bit CPU ALU. It processes an N-bit operand pair in W-bit slices, one slice per clock, through a registered ripple carry. The result carries 74-series-style carry/borrow semantics plus overflow and zero flags. It succeeds the single-cycle 4-bit combinational adder: wider operands, a subtract mode, status flags and a start/done handshake. It trades latency for a narrow slice adder.

---
 rtl/seq_addsub.sv | 143 ++++++++++++++
 tb/tb_seq_addsub.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle N-bit add/subtract built from a W-bit slice adder.
// The operands are processed one W-bit slice per clock, least significant
// slice first. The carry between slices is held in a register.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while busy=0
//   sub    0 = add, 1 = subtract (latched with start)
//   A, B   N-bit operands (latched with start)
//   C0     carry-in (add) / borrow-in (sub) (latched with start)
//   busy   operation in flight
//   done   one-cycle pulse when S and the flags update
//   S      N-bit result
//   CN     carry-out; in subtract mode 1 = no borrow
//   V      signed overflow
//   Z      S == 0
//
// N must be a multiple of W, and 1 <= W <= N.
module seq_addsub #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         C0,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
   output logic         CN,
   output logic         V,
   output logic         Z
);

   localparam int unsigned K  = N / W;
   localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic            r_sub;
   logic            r_carry;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_acc;

   logic [W-1:0]    w_a_sl;
   logic [W-1:0]    w_b_sl;
   logic [W:0]      w_slice;
   logic [W-1:0]    w_sum;
   logic            w_cout;
   logic            w_ovf;
   logic            w_last;
   logic [N-1:0]    w_res;
   int unsigned     w_base;

   // Slice adder for the slice selected by the counter, plus the merged result
   always_comb begin
      w_base  = 32'(r_cnt) * W;
      w_a_sl  = r_a[w_base +: W];
      // Subtract uses the inverted B slice; the inverted borrow-in was loaded
      // into the carry register when the operation was accepted.
      w_b_sl  = r_sub ? ~r_b[w_base +: W] : r_b[w_base +: W];
      w_slice = (W+1)'(w_a_sl) + (W+1)'(w_b_sl) + (W+1)'(r_carry);
      w_sum   = w_slice[W-1:0];
      w_cout  = w_slice[W];
      // Same-sign operands producing a different-sign sum is equivalent to
      // carry-into-MSB XOR carry-out-of-MSB, and also works for W=1.
      w_ovf   = (w_a_sl[W-1] == w_b_sl[W-1]) && (w_sum[W-1] != w_a_sl[W-1]);
      w_last  = (r_cnt == CW'(K - 1));
      w_res   = r_acc;
      w_res[w_base +: W] = w_sum;
   end

   // Control FSM, operand/carry registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         S       <= '0;
         CN      <= 1'b0;
         V       <= 1'b0;
         Z       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            // DONE accepts a new start exactly like IDLE, which gives the
            // back-to-back rate of one operation per K+1 cycles.
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_sub   <= sub;
                  r_carry <= sub ? ~C0 : C0;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_acc   <= w_res;
               r_carry <= w_cout;
               if (w_last) begin
                  S       <= w_res;
                  CN      <= w_cout;
                  V       <= w_ovf;
                  Z       <= (w_res == '0);
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed and random checks of seq_addsub against an
// arithmetic reference model (A +/- B +/- C0 with exact signed range test).
module tb_seq_addsub;

   parameter int unsigned N = 8;
   parameter int unsigned W = 4;
   localparam int unsigned K = N / W;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         C0;
   logic         busy;
   logic         done;
   logic [N-1:0] S;
   logic         CN;
   logic         V;
   logic         Z;

   int n_chk  = 0;
   int n_pass = 0;

   seq_addsub #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .A     (A),
      .B     (B),
      .C0    (C0),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .CN    (CN),
      .V     (V),
      .Z     (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: plain arithmetic on whole operands, signed overflow by range.
   task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c0, input logic s,
                        output logic [N-1:0] rs, output logic rcn,
                        output logic rv, output logic rz);
      longint ua, ub, sa, sb, r, lo, hi;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[N-1] ? ua - (longint'(1) << N) : ua;
      sb = b[N-1] ? ub - (longint'(1) << N) : ub;
      lo = -(longint'(1) << (N - 1));
      hi = (longint'(1) << (N - 1)) - 1;
      if (!s) begin
         r   = ua + ub + longint'(c0);
         rcn = (r >= (longint'(1) << N));
         r   = sa + sb + longint'(c0);
      end else begin
         r   = ua - ub - longint'(c0);
         rcn = (ua >= ub + longint'(c0));
         r   = sa - sb - longint'(c0);
      end
      rv = (r < lo) || (r > hi);
      rs = N'(r);
      rz = (rs == '0);
   endtask

   // One operation; with poke=1 start stays high and operands change while busy.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c0, input logic s, input bit poke,
                        input string tag);
      logic [N-1:0] es;
      logic ecn, ev, ez;
      bit   seen;
      int   lat;
      model(a, b, c0, s, es, ecn, ev, ez);
      @(negedge clk);
      A = a; B = b; C0 = c0; sub = s; start = 1'b1;
      @(posedge clk); #1;
      chk({tag, " busy_after_accept"}, 64'(busy), 64'(1));
      if (poke) begin
         A = ~a; B = a ^ b; C0 = ~c0; sub = ~s;
      end else begin
         start = 1'b0;
      end
      seen = 0;
      lat  = 0;
      for (int c = 1; c <= int'(K) + 4 && !seen; c++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1;
            lat  = c;
         end
      end
      start = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'(K));
      chk({tag, " S"},  64'(S),  64'(es));
      chk({tag, " CN"}, 64'(CN), 64'(ecn));
      chk({tag, " V"},  64'(V),  64'(ev));
      chk({tag, " Z"},  64'(Z),  64'(ez));
      chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
      @(posedge clk); #1;
      chk({tag, " done_pulse_end"}, 64'(done), 64'(0));
   endtask

   initial begin
      logic [N-1:0] es;
      logic ecn, ev, ez;
      logic [N-1:0] ra, rb;
      logic rc, rs;

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0; C0 = 1'b0;
      #3;
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst done", 64'(done), 64'(0));
      chk("rst S",    64'(S),    64'(0));
      chk("rst CN",   64'(CN),   64'(0));
      chk("rst V",    64'(V),    64'(0));
      chk("rst Z",    64'(Z),    64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      do_op(N'(8'h3C), N'(8'h05), 1'b0, 1'b0, 0, "add_plain");
      do_op(N'(8'h3C), N'(8'h05), 1'b1, 1'b0, 0, "add_c0");
      do_op(N'(8'hFF), N'(8'h01), 1'b0, 1'b0, 0, "add_wrap");
      do_op(N'(8'h0F), N'(8'h01), 1'b0, 1'b0, 0, "add_slice_carry");
      do_op(N'(8'h7F), N'(8'h01), 1'b0, 1'b0, 0, "add_ovf");
      do_op(N'(8'h80), N'(8'h01), 1'b0, 1'b1, 0, "sub_ovf");
      do_op(N'(8'h10), N'(8'h01), 1'b0, 1'b1, 0, "sub_plain");
      do_op(N'(8'h00), N'(8'h01), 1'b0, 1'b1, 0, "sub_borrow");
      do_op(N'(8'h05), N'(8'h04), 1'b1, 1'b1, 0, "sub_zero");
      do_op('1, '1, 1'b1, 1'b0, 0, "add_all_ones");
      do_op('0, '0, 1'b1, 1'b1, 0, "sub_zero_borrow");

      // start while busy and operand changes after latch are ignored
      do_op(N'(8'h3C), N'(8'h05), 1'b0, 1'b0, 1, "busy_ignore");
      do_op(N'(8'h80), N'(8'h01), 1'b1, 1'b1, 1, "busy_ignore_sub");

      // start held high: done every K+1 cycles
      model(N'(8'h21), N'(8'h13), 1'b1, 1'b0, es, ecn, ev, ez);
      @(negedge clk);
      A = N'(8'h21); B = N'(8'h13); C0 = 1'b1; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 3 * (int'(K) + 1) - 1; c++) begin
         @(posedge clk); #1;
         chk("b2b done", 64'(done), 64'((c % (int'(K) + 1)) == int'(K)));
         chk("b2b busy", 64'(busy), 64'((c % (int'(K) + 1)) != int'(K)));
         if ((c % (int'(K) + 1)) == int'(K))
            chk("b2b S", 64'(S), 64'(es));
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("b2b idle", 64'(busy), 64'(0));

      // Reset mid-operation
      do_op(N'(8'h7F), N'(8'h01), 1'b0, 1'b0, 0, "pre_reset");
      @(negedge clk);
      A = N'(8'h12); B = N'(8'h34); C0 = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mid_rst busy_before", 64'(busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst busy", 64'(busy), 64'(0));
      chk("mid_rst done", 64'(done), 64'(0));
      chk("mid_rst S",    64'(S),    64'(0));
      chk("mid_rst CN",   64'(CN),   64'(0));
      chk("mid_rst V",    64'(V),    64'(0));
      chk("mid_rst Z",    64'(Z),    64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < int'(K) + 3; c++) begin
         @(posedge clk); #1;
         chk("post_rst no_done", 64'(done), 64'(0));
      end
      do_op(N'(8'h12), N'(8'h34), 1'b0, 1'b0, 0, "after_reset");

      // Random sweep
      for (int i = 0; i < 500; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         do_op(ra, rb, rc, rs, 0, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
